// File: rtl/cp0_if.sv
// Decode-stage <-> CP0 signal bundle. The master modport is the datapath side
// and the slave modport is the CP0 unit.
interface cp0_if #(
  parameter int NUM_IRQ = 6
);
  logic [31:0]        ins;
  logic               ins_valid;
  logic [31:0]        pc;
  logic [31:0]        wdata;
  logic [NUM_IRQ-1:0] irq;
  logic [2:0]         cp0Op;
  logic [31:0]        rdata;
  logic               redirect;
  logic [31:0]        redirect_pc;
  logic               ins_kill;
  logic               exl;

  modport master (
    output ins, ins_valid, pc, wdata, irq,
    input  cp0Op, rdata, redirect, redirect_pc, ins_kill, exl
  );

  modport slave (
    input  ins, ins_valid, pc, wdata, irq,
    output cp0Op, rdata, redirect, redirect_pc, ins_kill, exl
  );
endinterface

// File: rtl/cp0_unit.sv
// CP0 for the multi-cycle MIPS core: decodes MFC0/MTC0/SYSCALL/ERET, holds Status/Cause/EPC/PRId
// and sequences exception entry/return. Define CP0_COUNT_EN to add the Count/Compare timer.
module cp0_unit #(
  parameter int          NUM_IRQ    = 6,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
  parameter logic [31:0] PRID_VAL   = 32'h0000_0001
) (
  input logic clk,
  input logic rst,
  cp0_if.slave bus
);
  localparam logic [2:0] OP_NONE = 3'b000;
  localparam logic [2:0] OP_MFC0 = 3'b001;
  localparam logic [2:0] OP_MTC0 = 3'b010;
  localparam logic [2:0] OP_SYSC = 3'b011;
  localparam logic [2:0] OP_ERET = 3'b100;

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_TRAP = 2'd1;
  localparam logic [1:0] ST_RET  = 2'd2;

  logic [4:0] rd;
  logic       is_mfc0, is_mtc0, is_sysc, is_eret;
  logic [2:0] cp0_op;

  assign rd      = bus.ins[15:11];
  assign is_mfc0 = (bus.ins[31:26] == 6'b010000) && (bus.ins[25:21] == 5'b00000) && (bus.ins[10:3] == 8'd0);
  assign is_mtc0 = (bus.ins[31:26] == 6'b010000) && (bus.ins[25:21] == 5'b00100) && (bus.ins[10:3] == 8'd0);
  assign is_sysc = (bus.ins[31:26] == 6'b000000) && (bus.ins[5:0] == 6'b001100);
  assign is_eret = (bus.ins == 32'h4200_0018);

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    cp0_op = OP_NONE;
    if (is_mfc0)      cp0_op = OP_MFC0;
    else if (is_mtc0) cp0_op = OP_MTC0;
    else if (is_sysc) cp0_op = OP_SYSC;
    else if (is_eret) cp0_op = OP_ERET;
  end
  assign bus.cp0Op = cp0_op;

  logic [1:0]         state_q, state_d;
  logic [7:0]         im_q, im_d;
  logic               exl_q, exl_d, ie_q, ie_d;
  logic [4:0]         exc_q, exc_d;
  logic [31:0]        epc_q, epc_d;
  logic [NUM_IRQ-1:0] ip_q;
  logic [7:0]         ip_field;
`ifdef CP0_COUNT_EN
  logic [31:0]        count_q, count_d, compare_q, compare_d;
  logic               timer_q, timer_d;
`endif

  // Cause.IP view: external lines in the low bits, the timer owns bit 15 when present.
  always_comb begin
    ip_field = '0;
    ip_field[NUM_IRQ-1:0] = ip_q;
`ifdef CP0_COUNT_EN
    ip_field[7] = ip_field[7] | timer_q;
`endif
  end

  logic take_irq;
  assign take_irq = bus.ins_valid & ie_q & ~exl_q & (|(ip_q & im_q[NUM_IRQ-1:0]));

  logic        redirect_c, kill_c;
  logic [31:0] rpc_c;

  always_comb begin
    state_d    = state_q;
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    exc_d      = exc_q;
    epc_d      = epc_q;
    redirect_c = 1'b0;
    kill_c     = 1'b0;
    rpc_c      = '0;
`ifdef CP0_COUNT_EN
    count_d    = count_q + 32'd1;
    compare_d  = compare_q;
    timer_d    = timer_q | (count_q == compare_q);
`endif
    case (state_q)
      ST_RUN: begin
        if (take_irq || (is_sysc && bus.ins_valid)) begin
          epc_d   = bus.pc;
          exc_d   = take_irq ? 5'd0 : 5'd8;
          exl_d   = 1'b1;
          kill_c  = 1'b1;
          state_d = ST_TRAP;
        end else if (is_eret && bus.ins_valid) begin
          exl_d   = 1'b0;
          state_d = ST_RET;
        end else if (is_mtc0 && bus.ins_valid) begin
          case (rd)
            5'd12: begin
              im_d  = bus.wdata[15:8];
              exl_d = bus.wdata[1];
              ie_d  = bus.wdata[0];
            end
            5'd14: epc_d = bus.wdata;
`ifdef CP0_COUNT_EN
            5'd9:  count_d = bus.wdata;
            5'd11: begin
              compare_d = bus.wdata;
              timer_d   = 1'b0;
            end
`endif
            default: ;
          endcase
        end
      end
      ST_TRAP: begin
        redirect_c = 1'b1;
        rpc_c      = EXC_VECTOR;
        kill_c     = 1'b1;
        state_d    = ST_RUN;
      end
      ST_RET: begin
        redirect_c = 1'b1;
        rpc_c      = epc_q;
        kill_c     = 1'b1;
        state_d    = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Reset must silence the datapath controls immediately, not at the next edge.
  assign bus.redirect    = redirect_c & ~rst;
  assign bus.ins_kill    = kill_c & ~rst;
  assign bus.redirect_pc = rst ? 32'd0 : rpc_c;
  assign bus.exl         = exl_q;

  always_comb begin
    bus.rdata = '0;
    case (rd)
      5'd12: bus.rdata = {16'd0, im_q, 6'd0, exl_q, ie_q};
      5'd13: bus.rdata = {16'd0, ip_field, 1'b0, exc_q, 2'b00};
      5'd14: bus.rdata = epc_q;
      5'd15: bus.rdata = PRID_VAL;
`ifdef CP0_COUNT_EN
      5'd9:  bus.rdata = count_q;
      5'd11: bus.rdata = compare_q;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q   <= ST_RUN;
      im_q      <= '0;
      exl_q     <= 1'b0;
      ie_q      <= 1'b0;
      exc_q     <= '0;
      epc_q     <= '0;
      ip_q      <= '0;
`ifdef CP0_COUNT_EN
      count_q   <= '0;
      compare_q <= '0;
      timer_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      im_q      <= im_d;
      exl_q     <= exl_d;
      ie_q      <= ie_d;
      exc_q     <= exc_d;
      epc_q     <= epc_d;
      ip_q      <= bus.irq;
`ifdef CP0_COUNT_EN
      count_q   <= count_d;
      compare_q <= compare_d;
      timer_q   <= timer_d;
`endif
    end
  end
endmodule

// File: tb/tb_cp0_unit.sv
// Self-checking bench for cp0_unit (default build): directed scenarios followed by random
// instruction streams, compared against an architectural model with a pending-redirect queue.
module tb_cp0_unit;
  localparam int          NIRQ    = 6;
  localparam logic [31:0] VEC     = 32'h0000_4180;
  localparam logic [31:0] PRID    = 32'h0000_0001;
  localparam logic [31:0] SYSCALL = 32'h0000_000C;
  localparam logic [31:0] ERET    = 32'h4200_0018;
  localparam logic [31:0] NOP     = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cp0_if #(.NUM_IRQ(NIRQ)) bus ();

  cp0_unit #(
    .NUM_IRQ   (NIRQ),
    .EXC_VECTOR(VEC),
    .PRID_VAL  (PRID)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Architectural model state
  logic [7:0]      m_im;
  logic            m_ie, m_exl;
  logic [4:0]      m_exc;
  logic [31:0]     m_epc;
  logic [NIRQ-1:0] m_ip;
  logic [31:0]     m_redir[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_im  = '0;
    m_ie  = 1'b0;
    m_exl = 1'b0;
    m_exc = '0;
    m_epc = '0;
    m_ip  = '0;
    m_redir.delete();
  endtask

  function automatic logic [31:0] mk_cop0(input logic [4:0] rs, input logic [4:0] rd);
    return {6'b010000, rs, 5'd8, rd, 11'd0};
  endfunction

  function automatic logic [2:0] ref_op(input logic [31:0] i);
    if (i == ERET) return 3'd4;
    if (i[31:26] == 6'd0 && i[5:0] == 6'd12) return 3'd3;
    if (i[31:26] == 6'd16 && i[10:3] == 8'd0 && i[25:21] == 5'd0) return 3'd1;
    if (i[31:26] == 6'd16 && i[10:3] == 8'd0 && i[25:21] == 5'd4) return 3'd2;
    return 3'd0;
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] r);
    case (r)
      5'd12:   return {16'd0, m_im, 6'd0, m_exl, m_ie};
      5'd13:   return (32'(m_ip) << 8) | (32'(m_exc) << 2);
      5'd14:   return m_epc;
      5'd15:   return PRID;
      default: return 32'd0;
    endcase
  endfunction

  // One decode cycle: drive at the falling edge, compare, then advance the model at the rising edge.
  task automatic step(input logic [31:0] i, input logic v, input logic [31:0] p,
                      input logic [31:0] wd, input logic [NIRQ-1:0] q);
    logic        busy, take, sc;
    logic [31:0] rpc;
    logic [2:0]  op;
    bus.ins = i; bus.ins_valid = v; bus.pc = p; bus.wdata = wd; bus.irq = q;
    #1;
    op   = ref_op(i);
    busy = (m_redir.size() != 0);
    rpc  = busy ? m_redir[0] : 32'd0;
    sc   = v && (op == 3'd4 - 3'd1);
    take = !busy && v && m_ie && !m_exl && ((m_ip & m_im[NIRQ-1:0]) != '0);
    check("cp0Op", 32'(bus.cp0Op), 32'(op));
    check("rdata", bus.rdata, ref_read(i[15:11]));
    check("redirect", 32'(bus.redirect), 32'(busy));
    check("redirect_pc", bus.redirect_pc, rpc);
    check("ins_kill", 32'(bus.ins_kill), 32'(busy || take || sc));
    check("exl", 32'(bus.exl), 32'(m_exl));
    @(posedge clk);
    if (busy) begin
      void'(m_redir.pop_front());
    end else if (take || sc) begin
      m_epc = p;
      m_exc = take ? 5'd0 : 5'd8;
      m_exl = 1'b1;
      m_redir.push_back(VEC);
    end else if (v && op == 3'd4) begin
      m_exl = 1'b0;
      m_redir.push_back(m_epc);
    end else if (v && op == 3'd2) begin
      if (i[15:11] == 5'd12) begin
        m_im  = wd[15:8];
        m_exl = wd[1];
        m_ie  = wd[0];
      end else if (i[15:11] == 5'd14) begin
        m_epc = wd;
      end
    end
    m_ip = q;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] ins, wd, p;
    logic        v;
    logic [NIRQ-1:0] q;
    int kind;

    // Reset: controls held low even with a SYSCALL presented; decode still follows the input.
    bus.ins = SYSCALL; bus.ins_valid = 1'b1; bus.pc = 32'h100; bus.wdata = '0; bus.irq = '0;
    #7;
    check("rst_redirect", 32'(bus.redirect), 32'd0);
    check("rst_kill", 32'(bus.ins_kill), 32'd0);
    check("rst_rpc", bus.redirect_pc, 32'd0);
    check("rst_cp0op", 32'(bus.cp0Op), 32'd3);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    step(mk_cop0(5'd0, 5'd15), 1'b1, 32'h0, 32'h0, '0);
    step(mk_cop0(5'd0, 5'd12), 1'b1, 32'h0, 32'h0, '0);

    // Interrupt entry: enable IM[10]/IE, hold irq[2] for two cycles.
    step(mk_cop0(5'd4, 5'd12), 1'b1, 32'h0, 32'h0000_0401, 6'b000100);
    step(NOP, 1'b1, 32'h3000, 32'h0, 6'b000100);
    check("irq_exl_set", 32'(bus.exl), 32'd1);
    check("irq_redirect", 32'(bus.redirect), 32'd1);
    step(mk_cop0(5'd0, 5'd14), 1'b1, 32'h0, 32'h0, '0);
    step(mk_cop0(5'd0, 5'd13), 1'b1, 32'h0, 32'h0, '0);

    // SYSCALL with IE=0, then ERET back to it.
    step(mk_cop0(5'd4, 5'd12), 1'b1, 32'h0, 32'h0000_0400, '0);
    step(SYSCALL, 1'b1, 32'h3010, 32'h0, '0);
    check("sys_cause", bus.rdata, 32'h0);
    step(mk_cop0(5'd0, 5'd13), 1'b1, 32'h0, 32'h0, '0);
    step(mk_cop0(5'd0, 5'd14), 1'b1, 32'h0, 32'h0, '0);
    step(ERET, 1'b1, 32'h3020, 32'h0, '0);
    check("eret_exl_clr", 32'(bus.exl), 32'd0);
    check("eret_rpc", bus.redirect_pc, 32'h3010);
    step(mk_cop0(5'd0, 5'd12), 1'b1, 32'h0, 32'h0, '0);
    step(NOP, 1'b1, 32'h3024, 32'h0, '0);

    // Interrupt beats a simultaneous SYSCALL; with EXL set it is then held off.
    step(mk_cop0(5'd4, 5'd12), 1'b1, 32'h0, 32'h0000_0401, 6'b000100);
    step(SYSCALL, 1'b1, 32'h3020, 32'h0, 6'b000100);
    step(mk_cop0(5'd0, 5'd13), 1'b1, 32'h0, 32'h0, 6'b000100);
    step(NOP, 1'b1, 32'h3030, 32'h0, 6'b000100);
    step(ERET, 1'b1, 32'h3034, 32'h0, '0);
    step(mk_cop0(5'd0, 5'd14), 1'b1, 32'h0, 32'h0, '0);

    // Asynchronous reset in the middle of the TRAP cycle.
    step(SYSCALL, 1'b1, 32'h3040, 32'h0, '0);
    check("pre_rst_redirect", 32'(bus.redirect), 32'd1);
    bus.ins = mk_cop0(5'd0, 5'd14);
    #1 rst = 1'b1;
    #1;
    check("async_rst_redirect", 32'(bus.redirect), 32'd0);
    check("async_rst_kill", 32'(bus.ins_kill), 32'd0);
    check("async_rst_rpc", bus.redirect_pc, 32'd0);
    check("async_rst_epc", bus.rdata, 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(mk_cop0(5'd0, 5'd12), 1'b1, 32'h0, 32'h0, '0);
    step(mk_cop0(5'd0, 5'd13), 1'b1, 32'h0, 32'h0, '0);
    step(mk_cop0(5'd0, 5'd14), 1'b1, 32'h0, 32'h0, '0);

    // Random instruction streams against the model.
    for (int n = 0; n < 400; n++) begin
      kind = int'($urandom_range(0, 9));
      wd   = $urandom;
      p    = {$urandom_range(0, 32'hFFFF), 2'b00};
      v    = ($urandom_range(0, 7) != 0);
      q    = ($urandom_range(0, 3) == 0) ? NIRQ'($urandom) : '0;
      case (kind)
        0, 1, 2: ins = mk_cop0(5'd0, 5'($urandom_range(8, 16)));
        3, 4:    ins = mk_cop0(5'd4, ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(12, 14)));
        5:       ins = SYSCALL | {6'd0, 20'($urandom), 6'd0};
        6:       ins = ERET;
        default: ins = $urandom;
      endcase
      step(ins, v, p, wd, q);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
